// File: rtl/debug_pkg.sv
// Shared definitions for the pipeline debug unit: command/response bytes,
// FSM state encoding and latch dump lengths.
// Optional build macro: DEBUG_LATCH_DUMP_EN (adds the pipeline-latch dump).
package debug_pkg;

  // Host command bytes
  localparam logic [7:0] CMD_LOAD   = 8'h4C;  // 'L'
  localparam logic [7:0] CMD_CONT   = 8'h43;  // 'C'
  localparam logic [7:0] CMD_STEP   = 8'h53;  // 'S'

  // Response / trailer bytes
  localparam logic [7:0] RSP_ACK    = 8'h4B;
  localparam logic [7:0] RSP_ERR    = 8'h3F;
  localparam logic [7:0] RSP_ENDED  = 8'hE0;
  localparam logic [7:0] TRAIL_END  = 8'hEE;
  localparam logic [7:0] TRAIL_STEP = 8'h5E;

  // Latch widths rounded up to whole bytes
  localparam int LATCH_IF_ID_BYTES  = 8;
  localparam int LATCH_ID_EX_BYTES  = 18;
  localparam int LATCH_EX_MEM_BYTES = 10;
  localparam int LATCH_MEM_WB_BYTES = 9;
  localparam int LATCH_MAX_BYTES    = 18;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD_CNT,
    ST_LOAD_BYTE,
    ST_RUN,
    ST_STEP,
    ST_DUMP_CYC,
    ST_DUMP_REG,
    ST_DUMP_MEM,
    ST_DUMP_LATCH,
    ST_DUMP_TRAIL
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debug_word_tx.sv
// Serializes a word of 'len' bytes, MSB byte first, over a valid/ready
// byte handshake. The word is captured on start, so the source may change
// while the bytes drain. 'done' is high on the handshake of the last byte.
module debug_word_tx
  import debug_pkg::*;
#(
  parameter int MAX_BYTES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [7:0]             len,
  input  logic [MAX_BYTES*8-1:0] word,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic                   busy,
  output logic                   done
);

  logic [MAX_BYTES*8-1:0] sh_q;
  logic [7:0]             cnt_q;
  logic                   valid_q;

  assign tx_data  = sh_q[MAX_BYTES*8-1 -: 8];
  assign tx_valid = valid_q;
  assign busy     = valid_q;
  assign done     = valid_q & tx_ready & (cnt_q == 8'd1);

  // Left-align the word so its MSB byte sits on tx_data, then shift per handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q    <= '0;
      cnt_q   <= 8'd0;
      valid_q <= 1'b0;
    end else if (!valid_q) begin
      if (start) begin
        sh_q    <= word << (8 * (MAX_BYTES - int'(len)));
        cnt_q   <= len;
        valid_q <= 1'b1;
      end
    end else if (tx_ready) begin
      sh_q  <= sh_q << 8;
      cnt_q <= cnt_q - 8'd1;
      if (cnt_q == 8'd1) valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/debug_unit.sv
// Host debug controller for the MIPS pipeline: loads instruction memory,
// runs the pipeline continuously or one cycle at a time, then streams back
// the cycle count, register file, data memory and a trailer byte.
// Optional build macro: DEBUG_LATCH_DUMP_EN (dumps IF_ID/ID_EX/EX_MEM/MEM_WB
// snapshots after data memory).
module debug_unit
  import debug_pkg::*;
#(
  parameter int N_REGS      = 32,
  parameter int N_MEM_WORDS = 32,
  parameter int NB_CYCLES   = 32
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic [7:0]   i_rx_data,
  input  logic         i_rx_valid,
  output logic [7:0]   o_tx_data,
  output logic         o_tx_valid,
  input  logic         i_tx_ready,
  output logic         o_stop,
  output logic         o_pipe_reset,
  output logic         o_write_instruction_mem,
  output logic [31:0]  o_instruction_mem_addr,
  output logic [31:0]  o_instruction_mem_data,
  output logic [4:0]   o_r_addr_registers,
  input  logic [31:0]  i_r_data_registers,
  output logic [4:0]   o_r_addr_data_mem,
  input  logic [31:0]  i_r_data_data_mem,
  input  logic         i_end,
  input  logic [63:0]  i_IF_ID,
  input  logic [138:0] i_ID_EX,
  input  logic [75:0]  i_EX_MEM,
  input  logic [70:0]  i_MEM_WB,
  output logic         o_busy
);

  localparam int CYC_BYTES = NB_CYCLES / 8;
`ifdef DEBUG_LATCH_DUMP_EN
  localparam int TX_BYTES = max_int(max_int(CYC_BYTES, 4), LATCH_MAX_BYTES);
`else
  localparam int TX_BYTES = max_int(CYC_BYTES, 4);
`endif
  localparam int TX_W = TX_BYTES * 8;

  state_e               state;
  logic                 stop_q;
  logic [NB_CYCLES-1:0] cycle_cnt;
  logic [7:0]           n_words;
  logic [7:0]           load_idx;
  logic [1:0]           byte_cnt;
  logic [23:0]          asm_q;
  logic [15:0]          word_idx;
  logic                 launched;
  logic [4:0]           reg_addr;
  logic [4:0]           mem_addr;

  logic                 tx_start;
  logic [7:0]           tx_len;
  logic [TX_W-1:0]      tx_word;
  logic                 tx_busy;
  logic                 tx_done;

  logic                 cmd_ok;
  logic                 last_word;

  function automatic logic [NB_CYCLES-1:0] sat_inc(input logic [NB_CYCLES-1:0] v);
    return (&v) ? v : v + NB_CYCLES'(1);
  endfunction

  // A command is only taken when no response byte is still draining
  assign cmd_ok    = i_rx_valid & ~tx_busy;
  assign last_word = ((load_idx + 8'd1) == n_words);

  // Halt seen during RUN freezes the pipeline in that same cycle
  assign o_stop             = stop_q | ((state == ST_RUN) & i_end);
  assign o_busy             = (state != ST_IDLE);
  assign o_r_addr_registers = reg_addr;
  assign o_r_addr_data_mem  = mem_addr;

`ifdef DEBUG_LATCH_DUMP_EN
  logic [63:0]  snap_if_id;
  logic [138:0] snap_id_ex;
  logic [75:0]  snap_ex_mem;
  logic [70:0]  snap_mem_wb;
  logic [1:0]   latch_idx;
  logic [TX_W-1:0] latch_word;
  logic [7:0]   latch_len;
  logic         dump_entry;

  assign dump_entry = ((state == ST_RUN) & i_end) | (state == ST_STEP);

  // Freeze the latches at dump entry so the dumped image is coherent
  always_ff @(posedge i_clk) begin
    if (dump_entry) begin
      snap_if_id  <= i_IF_ID;
      snap_id_ex  <= i_ID_EX;
      snap_ex_mem <= i_EX_MEM;
      snap_mem_wb <= i_MEM_WB;
    end
  end

  // Select the snapshot being dumped, zero-extended to its byte length
  always_comb begin
    latch_word = '0;
    latch_len  = 8'(LATCH_IF_ID_BYTES);
    case (latch_idx)
      2'd0: begin latch_word = TX_W'(snap_if_id);  latch_len = 8'(LATCH_IF_ID_BYTES);  end
      2'd1: begin latch_word = TX_W'(snap_id_ex);  latch_len = 8'(LATCH_ID_EX_BYTES);  end
      2'd2: begin latch_word = TX_W'(snap_ex_mem); latch_len = 8'(LATCH_EX_MEM_BYTES); end
      default: begin latch_word = TX_W'(snap_mem_wb); latch_len = 8'(LATCH_MEM_WB_BYTES); end
    endcase
  end
`else
  logic unused_latches;
  assign unused_latches = ^{i_IF_ID, i_ID_EX, i_EX_MEM, i_MEM_WB};
`endif

  // Decide which word (if any) the serializer starts this cycle
  always_comb begin
    tx_start = 1'b0;
    tx_len   = 8'd1;
    tx_word  = '0;
    case (state)
      ST_IDLE: begin
        if (cmd_ok) begin
          if ((i_rx_data == CMD_CONT) || (i_rx_data == CMD_STEP)) begin
            tx_start = i_end;
            tx_word  = TX_W'(RSP_ENDED);
          end else if (i_rx_data != CMD_LOAD) begin
            tx_start = 1'b1;
            tx_word  = TX_W'(RSP_ERR);
          end
        end
      end
      ST_LOAD_CNT: begin
        if (i_rx_valid && (i_rx_data == 8'd0)) begin
          tx_start = 1'b1;
          tx_word  = TX_W'(RSP_ACK);
        end
      end
      ST_LOAD_BYTE: begin
        if (i_rx_valid && (byte_cnt == 2'd3) && last_word) begin
          tx_start = 1'b1;
          tx_word  = TX_W'(RSP_ACK);
        end
      end
      ST_DUMP_CYC: begin
        tx_start = ~launched;
        tx_len   = 8'(CYC_BYTES);
        tx_word  = TX_W'(cycle_cnt);
      end
      ST_DUMP_REG: begin
        tx_start = ~launched;
        tx_len   = 8'd4;
        tx_word  = TX_W'(i_r_data_registers);
      end
      ST_DUMP_MEM: begin
        tx_start = ~launched;
        tx_len   = 8'd4;
        tx_word  = TX_W'(i_r_data_data_mem);
      end
`ifdef DEBUG_LATCH_DUMP_EN
      ST_DUMP_LATCH: begin
        tx_start = ~launched;
        tx_len   = latch_len;
        tx_word  = latch_word;
      end
`endif
      ST_DUMP_TRAIL: begin
        tx_start = ~launched;
        tx_word  = TX_W'(i_end ? TRAIL_END : TRAIL_STEP);
      end
      default: ;
    endcase
  end

  // Instruction word assembly; only the first three bytes need holding
  always_ff @(posedge i_clk) begin
    if ((state == ST_LOAD_BYTE) && i_rx_valid) asm_q <= {asm_q[15:0], i_rx_data};
  end

  // Main sequencer: command decode, load, run/step and dump sequencing
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state                   <= ST_IDLE;
      stop_q                  <= 1'b1;
      cycle_cnt               <= '0;
      n_words                 <= 8'd0;
      load_idx                <= 8'd0;
      byte_cnt                <= 2'd0;
      word_idx                <= 16'd0;
      launched                <= 1'b0;
      reg_addr                <= 5'd0;
      mem_addr                <= 5'd0;
      o_pipe_reset            <= 1'b0;
      o_write_instruction_mem <= 1'b0;
      o_instruction_mem_addr  <= 32'd0;
      o_instruction_mem_data  <= 32'd0;
`ifdef DEBUG_LATCH_DUMP_EN
      latch_idx               <= 2'd0;
`endif
    end else begin
      o_pipe_reset            <= 1'b0;
      o_write_instruction_mem <= 1'b0;
      if (tx_start) launched <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (cmd_ok) begin
            if (i_rx_data == CMD_LOAD) begin
              o_pipe_reset <= 1'b1;
              cycle_cnt    <= '0;
              state        <= ST_LOAD_CNT;
            end else if ((i_rx_data == CMD_CONT) && !i_end) begin
              stop_q <= 1'b0;
              state  <= ST_RUN;
            end else if ((i_rx_data == CMD_STEP) && !i_end) begin
              stop_q <= 1'b0;
              state  <= ST_STEP;
            end
          end
          launched <= 1'b0;
        end
        ST_LOAD_CNT: begin
          launched <= 1'b0;
          if (i_rx_valid) begin
            n_words  <= i_rx_data;
            load_idx <= 8'd0;
            byte_cnt <= 2'd0;
            state    <= (i_rx_data == 8'd0) ? ST_IDLE : ST_LOAD_BYTE;
          end
        end
        ST_LOAD_BYTE: begin
          launched <= 1'b0;
          if (i_rx_valid) begin
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              o_write_instruction_mem <= 1'b1;
              o_instruction_mem_addr  <= {22'd0, load_idx, 2'b00};
              o_instruction_mem_data  <= {asm_q, i_rx_data};
              load_idx                <= load_idx + 8'd1;
              if (last_word) state <= ST_IDLE;
            end
          end
        end
        ST_RUN: begin
          if (i_end) begin
            stop_q <= 1'b1;
            state  <= ST_DUMP_CYC;
          end else begin
            cycle_cnt <= sat_inc(cycle_cnt);
          end
        end
        ST_STEP: begin
          cycle_cnt <= sat_inc(cycle_cnt);
          stop_q    <= 1'b1;
          state     <= ST_DUMP_CYC;
        end
        ST_DUMP_CYC: begin
          if (tx_done) begin
            launched <= 1'b0;
            word_idx <= 16'd0;
            reg_addr <= 5'd0;
            state    <= ST_DUMP_REG;
          end
        end
        ST_DUMP_REG: begin
          if (tx_done) begin
            launched <= 1'b0;
            if (word_idx == 16'(N_REGS - 1)) begin
              word_idx <= 16'd0;
              mem_addr <= 5'd0;
              state    <= ST_DUMP_MEM;
            end else begin
              word_idx <= word_idx + 16'd1;
              reg_addr <= reg_addr + 5'd1;
            end
          end
        end
        ST_DUMP_MEM: begin
          if (tx_done) begin
            launched <= 1'b0;
            if (word_idx == 16'(N_MEM_WORDS - 1)) begin
              word_idx <= 16'd0;
`ifdef DEBUG_LATCH_DUMP_EN
              latch_idx <= 2'd0;
              state     <= ST_DUMP_LATCH;
`else
              state     <= ST_DUMP_TRAIL;
`endif
            end else begin
              word_idx <= word_idx + 16'd1;
              mem_addr <= mem_addr + 5'd1;
            end
          end
        end
`ifdef DEBUG_LATCH_DUMP_EN
        ST_DUMP_LATCH: begin
          if (tx_done) begin
            launched <= 1'b0;
            if (latch_idx == 2'd3) state <= ST_DUMP_TRAIL;
            else                   latch_idx <= latch_idx + 2'd1;
          end
        end
`endif
        ST_DUMP_TRAIL: begin
          if (tx_done) begin
            launched <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  debug_word_tx #(
    .MAX_BYTES (TX_BYTES)
  ) u_word_tx (
    .clk      (i_clk),
    .rst_n    (i_reset),
    .start    (tx_start),
    .len      (tx_len),
    .word     (tx_word),
    .tx_data  (o_tx_data),
    .tx_valid (o_tx_valid),
    .tx_ready (i_tx_ready),
    .busy     (tx_busy),
    .done     (tx_done)
  );

endmodule
